// File: rtl/timer_pkg.sv
// Shared definitions for the min:sec:ms timer core.
//   - Field widths for the minute/second/millisecond counters.
//   - Default roll-over limits for each field.
//   - State encoding (2 bits) and the matching enum used by the FSM.
//   - sat_field(): clamps a preset value to a field maximum.
package timer_pkg;

  localparam int MS_W  = 10;
  localparam int SEC_W = 6;
  localparam int MIN_W = 6;

  localparam int MS_MAX_DEF  = 999;
  localparam int SEC_MAX_DEF = 59;
  localparam int MIN_MAX_DEF = 59;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_PAUSE = ST_PAUSE,
    S_DONE  = ST_DONE
  } state_t;

  // Presets above the field limit saturate at the limit.
  function automatic logic [5:0] sat_field(input logic [5:0] value, input int max_val);
    return (int'(value) > max_val) ? 6'(max_val) : value;
  endfunction

endpackage

// File: rtl/timer_min_sec_core_if.sv
// Command/status bundle between the timer core and its neighbours.
//   master : drives tick_1k, buttons, load preset, mode_down; reads the count.
//   slave  : the timer core itself.
interface timer_min_sec_core_if;
  import timer_pkg::*;

  logic             tick_1k;
  logic             btn_run;
  logic             btn_clear;
  logic             load_en;
  logic [MIN_W-1:0] load_min;
  logic [SEC_W-1:0] load_sec;
  logic             mode_down;

  logic [MIN_W-1:0] min;
  logic [SEC_W-1:0] sec;
  logic [MS_W-1:0]  msec;
  logic             running;
  logic             sec_tick;
  logic             done;

  modport master (
    output tick_1k, btn_run, btn_clear, load_en, load_min, load_sec, mode_down,
    input  min, sec, msec, running, sec_tick, done
  );

  modport slave (
    input  tick_1k, btn_run, btn_clear, load_en, load_min, load_sec, mode_down,
    output min, sec, msec, running, sec_tick, done
  );

endinterface

// File: rtl/timer_min_sec_core_rise_edge_detect.sv
// Rising-edge detector for a signal already in the clk domain.
//   clk, rst : system clock, asynchronous active-high reset
//   i_din    : level input
//   o_pulse  : one-cycle pulse in the cycle i_din is high after being low
module rise_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  output logic o_pulse
);

  logic r_din_d;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_din_d <= 1'b0;
    else     r_din_d <= i_din;
  end

  assign o_pulse = i_din & ~r_din_d;

endmodule

// File: rtl/timer_min_sec_core.sv
// Min:sec:ms stopwatch / countdown core.
//   clk, rst : 100 MHz system clock, asynchronous active-high reset
//   bus      : slave side of timer_min_sec_core_if
//              in : tick_1k (1 kHz square wave, clk domain), btn_run,
//                   btn_clear, load_en, load_min, load_sec, mode_down
//              out: min, sec, msec, running, sec_tick, done (all registered)
module timer_min_sec_core
  import timer_pkg::*;
#(
  parameter int MS_MAX  = MS_MAX_DEF,
  parameter int SEC_MAX = SEC_MAX_DEF,
  parameter int MIN_MAX = MIN_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  timer_min_sec_core_if.slave  bus
);

  localparam logic [MS_W-1:0]  L_MS_MAX  = MS_W'(MS_MAX);
  localparam logic [SEC_W-1:0] L_SEC_MAX = SEC_W'(SEC_MAX);
  localparam logic [MIN_W-1:0] L_MIN_MAX = MIN_W'(MIN_MAX);

  state_t           r_state, w_state_nxt;
  logic [MIN_W-1:0] r_min, w_min_nxt;
  logic [SEC_W-1:0] r_sec, w_sec_nxt;
  logic [MS_W-1:0]  r_msec, w_msec_nxt;
  logic             r_running, r_sec_tick, w_sec_tick_nxt, r_done, w_done_nxt;
  logic             w_ms_en, w_is_zero;
  logic [MIN_W-1:0] w_load_min;
  logic [SEC_W-1:0] w_load_sec;

  rise_edge_detect u_tick_edge (
    .clk     (clk),
    .rst     (rst),
    .i_din   (bus.tick_1k),
    .o_pulse (w_ms_en)
  );

  assign w_is_zero  = (r_min == '0) && (r_sec == '0) && (r_msec == '0);
  assign w_load_min = sat_field(bus.load_min, MIN_MAX);
  assign w_load_sec = sat_field(bus.load_sec, SEC_MAX);

  // NOTE: every signal written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_min_nxt      = r_min;
    w_sec_nxt      = r_sec;
    w_msec_nxt     = r_msec;
    w_sec_tick_nxt = 1'b0;
    w_done_nxt     = 1'b0;

    // Clear and load share one encoding in every state that honours them.
    if (bus.btn_clear) begin
      w_min_nxt  = '0;
      w_sec_nxt  = '0;
      w_msec_nxt = '0;
    end else if (bus.load_en && r_state != S_RUN) begin
      w_min_nxt  = w_load_min;
      w_sec_nxt  = w_load_sec;
      w_msec_nxt = '0;
    end

    unique case (r_state)
      S_IDLE: begin
        if (!bus.btn_clear && !bus.load_en && bus.btn_run &&
            !(bus.mode_down && w_is_zero))
          w_state_nxt = S_RUN;
      end

      S_RUN: begin
        if (bus.btn_clear) begin
          w_state_nxt = S_IDLE;
        end else begin
          if (bus.btn_run) w_state_nxt = S_PAUSE;
          if (w_ms_en) begin
            if (!bus.mode_down) begin
              if (r_msec == L_MS_MAX) begin
                w_msec_nxt     = '0;
                w_sec_tick_nxt = 1'b1;
                if (r_sec == L_SEC_MAX) begin
                  w_sec_nxt = '0;
                  w_min_nxt = (r_min == L_MIN_MAX) ? '0 : r_min + 1'b1;
                end else begin
                  w_sec_nxt = r_sec + 1'b1;
                end
              end else begin
                w_msec_nxt = r_msec + 1'b1;
              end
            end else begin
              // Already at zero (direction flipped mid-run): no decrement.
              if (!w_is_zero) begin
                if (r_msec == '0) begin
                  w_msec_nxt     = L_MS_MAX;
                  w_sec_tick_nxt = 1'b1;
                  if (r_sec == '0) begin
                    w_sec_nxt = L_SEC_MAX;
                    w_min_nxt = r_min - 1'b1;
                  end else begin
                    w_sec_nxt = r_sec - 1'b1;
                  end
                end else begin
                  w_msec_nxt = r_msec - 1'b1;
                end
              end
              // Reaching zero ends the countdown even if pause was pressed.
              if (w_min_nxt == '0 && w_sec_nxt == '0 && w_msec_nxt == '0) begin
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
              end
            end
          end
        end
      end

      S_PAUSE: begin
        if (bus.btn_clear || bus.load_en) w_state_nxt = S_IDLE;
        else if (bus.btn_run)             w_state_nxt = S_RUN;
      end

      S_DONE: begin
        if (bus.btn_clear || bus.load_en) w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_min      <= '0;
      r_sec      <= '0;
      r_msec     <= '0;
      r_running  <= 1'b0;
      r_sec_tick <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_min      <= w_min_nxt;
      r_sec      <= w_sec_nxt;
      r_msec     <= w_msec_nxt;
      r_running  <= (w_state_nxt == S_RUN);
      r_sec_tick <= w_sec_tick_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign bus.min      = r_min;
  assign bus.sec      = r_sec;
  assign bus.msec     = r_msec;
  assign bus.running  = r_running;
  assign bus.sec_tick = r_sec_tick;
  assign bus.done     = r_done;

endmodule
